// File: rtl/divisor_sequencial_8bits_pkg.sv
// Shared definitions for the sequential 8-bit divider: state encodings,
// datapath width and the index of the final iteration.
package divisor_sequencial_8bits_pkg;

  localparam int DIV_WIDTH = 8;
  localparam logic [2:0] DIV_LAST_ITER = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/somador_algebrico_8bits.sv
// 8-bit algebraic adder: adds or subtracts b from a, and reports the
// unsigned magnitude comparison of the two operands.
module somador_algebrico_8bits (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       sum_subtract,
  output logic [7:0] a_plus_b_or_a_minus_b,
  output logic       b_greater_than_a,
  output logic       a_equals_b
);

  // sum_subtract = 1 selects a - b (two's complement add of ~b + 1)
  always_comb begin
    a_plus_b_or_a_minus_b = sum_subtract ? (a - b) : (a + b);
    b_greater_than_a      = (b > a);
    a_equals_b            = (a == b);
  end

endmodule

// File: rtl/divisor_sequencial_8bits.sv
// Sequential 8-bit unsigned restoring divider. One quotient bit per cycle,
// using a shared algebraic adder fixed in subtract mode.
module divisor_sequencial_8bits
  import divisor_sequencial_8bits_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [DIV_WIDTH-1:0] dividend,
  input  logic [DIV_WIDTH-1:0] divisor,
  output logic [DIV_WIDTH-1:0] quotient,
  output logic [DIV_WIDTH-1:0] remainder,
  output logic                 busy,
  output logic                 done,
  output logic                 div_by_zero
);

  div_state_t           state_reg;
  logic [2:0]           counter_reg;
  logic [DIV_WIDTH-1:0] r_reg;
  logic [DIV_WIDTH-1:0] q_reg;
  logic [DIV_WIDTH-1:0] d_reg;

  logic [DIV_WIDTH-1:0] shifted;
  logic [DIV_WIDTH-1:0] diff;
  logic                 msb;
  logic                 b_gt;
  logic                 adder_eq_unused;
  logic                 sub_ok;
  logic [DIV_WIDTH-1:0] r_next;
  logic [DIV_WIDTH-1:0] q_next;

  somador_algebrico_8bits u_adder (
    .a                     (shifted),
    .b                     (d_reg),
    .sum_subtract          (1'b1),
    .a_plus_b_or_a_minus_b (diff),
    .b_greater_than_a      (b_gt),
    .a_equals_b            (adder_eq_unused)
  );

  // A set msb means the shifted partial remainder is >= 256 > D, so the
  // subtraction always succeeds and the truncated 8-bit difference is exact.
  always_comb begin
    shifted = {r_reg[DIV_WIDTH-2:0], q_reg[DIV_WIDTH-1]};
    msb     = r_reg[DIV_WIDTH-1];
    sub_ok  = msb | ~b_gt;
    r_next  = sub_ok ? diff : shifted;
    q_next  = {q_reg[DIV_WIDTH-2:0], sub_ok};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      counter_reg <= 3'd0;
      r_reg       <= '0;
      q_reg       <= '0;
      d_reg       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          done <= 1'b0;
          busy <= 1'b0;
          if (start) begin
            if (divisor == '0) begin
              quotient    <= 8'hFF;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              done        <= 1'b1;
              state_reg   <= DONE;
            end else begin
              d_reg       <= divisor;
              q_reg       <= dividend;
              r_reg       <= '0;
              counter_reg <= 3'd0;
              div_by_zero <= 1'b0;
              busy        <= 1'b1;
              state_reg   <= RUN;
            end
          end
        end
        RUN: begin
          r_reg       <= r_next;
          q_reg       <= q_next;
          counter_reg <= counter_reg + 3'd1;
          if (counter_reg == DIV_LAST_ITER) begin
            quotient  <= q_next;
            remainder <= r_next;
            busy      <= 1'b0;
            done      <= 1'b1;
            state_reg <= DONE;
          end
        end
        DONE: begin
          done      <= 1'b0;
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          done      <= 1'b0;
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule
